// File: rtl/bcd_count_ctrl_pkg.sv
// Shared state encodings and digit constants for the BCD count blocks.
// Imported by the display driver and future BCD logic as well.
package bcd_count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_inc12.sv
// bcd_inc12: 3-digit BCD incrementor, 999 rolls to 000.
// Purely combinational; digits assumed 0-9 on input.
module bcd_inc12
    import bcd_count_ctrl_pkg::*;
(
    input  logic [11:0] din,
    output logic [11:0] dout
);

    always_comb begin
        logic c;
        dout = din;
        c    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                if (din[4*i +: 4] >= BCD_DIGIT_MAX) begin
                    dout[4*i +: 4] = 4'd0;
                end else begin
                    dout[4*i +: 4] = din[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: start/stop/clear sequencer around bcd_inc12.
// Define BCD_CNT_LOAD_EN to add the load/ld2..ld0 preset ports.
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter logic [3:0] TERM2        = 4'd9,
    parameter logic [3:0] TERM1        = 4'd9,
    parameter logic [3:0] TERM0        = 4'd9,
    parameter bit         STOP_AT_TERM = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       tick,
`ifdef BCD_CNT_LOAD_EN
    input  logic       load,
    input  logic [3:0] ld2,
    input  logic [3:0] ld1,
    input  logic [3:0] ld0,
`endif
    output logic [3:0] out2,
    output logic [3:0] out1,
    output logic [3:0] out0,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    localparam logic [11:0] TERM = {TERM2, TERM1, TERM0};

    if (TERM2 > BCD_DIGIT_MAX || TERM1 > BCD_DIGIT_MAX ||
        TERM0 > BCD_DIGIT_MAX) begin : g_bad_term
        $error("bcd_count_ctrl: TERM digit above 9");
    end

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d, cnt_inc, ld_val;
    logic        wrap_q, wrap_d;
    logic        load_ok;

    bcd_inc12 u_inc (
        .din  (cnt_q),
        .dout (cnt_inc)
    );

`ifdef BCD_CNT_LOAD_EN
    // Presets only land while the count is parked.
    assign load_ok = load &&
        (state_q == ST_IDLE || state_q == ST_HOLD);
    assign ld_val  = {clamp_digit(ld2), clamp_digit(ld1),
                      clamp_digit(ld0)};
`else
    assign load_ok = 1'b0;
    assign ld_val  = 12'd0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 12'd0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = 12'd0;
        end else if (load_ok) begin
            cnt_d = ld_val;
        end else if (stop && state_q == ST_RUN) begin
            state_d = ST_HOLD;
        end else if (start &&
                     (state_q == ST_IDLE || state_q == ST_HOLD)) begin
            state_d = ST_RUN;
        end else if (tick && state_q == ST_RUN) begin
            if (cnt_q != TERM) begin
                cnt_d = cnt_inc;
            end else if (STOP_AT_TERM) begin
                state_d = ST_DONE;
            end else begin
                cnt_d  = 12'd0;
                wrap_d = 1'b1;
            end
        end
    end

    always_comb begin
        {out2, out1, out0} = cnt_q;
        running = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        wrap    = wrap_q;
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl: two instances (stop / wrap),
// an arithmetic reference model, and directed literal checks.
module tb_bcd_count_ctrl;

    localparam int IDLE = 0, RUN = 1, HOLD = 2, DONE = 3;
`ifdef BCD_CNT_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 0, stop = 0, clear = 0, tick = 0, load = 0;
    logic [3:0] ld2 = 0, ld1 = 0, ld0 = 0;

    logic [3:0] a2, a1, a0, b2, b1, b0;
    logic arun, adone, awrap, brun, bdone, bwrap;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bcd_count_ctrl #(.TERM2(4'd0), .TERM1(4'd1), .TERM0(4'd2),
                     .STOP_AT_TERM(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .clear(clear), .tick(tick),
`ifdef BCD_CNT_LOAD_EN
        .load(load), .ld2(ld2), .ld1(ld1), .ld0(ld0),
`endif
        .out2(a2), .out1(a1), .out0(a0),
        .running(arun), .done(adone), .wrap(awrap)
    );

    bcd_count_ctrl #(.TERM2(4'd1), .TERM1(4'd0), .TERM0(4'd5),
                     .STOP_AT_TERM(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .clear(clear), .tick(tick),
`ifdef BCD_CNT_LOAD_EN
        .load(load), .ld2(ld2), .ld1(ld1), .ld0(ld0),
`endif
        .out2(b2), .out1(b1), .out0(b0),
        .running(brun), .done(bdone), .wrap(bwrap)
    );

    // Reference model: count held as a plain integer 0..999
    int m_cnt[2];
    int m_st[2];
    bit m_wr[2];
    int termv[2] = '{12, 105};
    bit stopat[2] = '{1'b1, 1'b0};

    function automatic int min9(input logic [3:0] d);
        return (d > 9) ? 9 : int'(d);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] <= 0;
                m_st[k]  <= IDLE;
                m_wr[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int c;
                int s;
                bit w;
                c = m_cnt[k];
                s = m_st[k];
                w = 1'b0;
                if (clear) begin
                    c = 0;
                    s = IDLE;
                end else if (LOAD_EN && load && (s == IDLE || s == HOLD)) begin
                    c = 100 * min9(ld2) + 10 * min9(ld1) + min9(ld0);
                end else if (stop && s == RUN) begin
                    s = HOLD;
                end else if (start && (s == IDLE || s == HOLD)) begin
                    s = RUN;
                end else if (tick && s == RUN) begin
                    if (c != termv[k]) c = (c + 1) % 1000;
                    else if (stopat[k]) s = DONE;
                    else begin
                        c = 0;
                        w = 1'b1;
                    end
                end
                m_cnt[k] <= c;
                m_st[k]  <= s;
                m_wr[k]  <= w;
            end
        end
    end

    function automatic logic [14:0] expect_vec(input int k);
        int c;
        c = m_cnt[k];
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10),
                m_st[k] == RUN, m_st[k] == DONE, m_wr[k]};
    endfunction

    logic [14:0] act_a, act_b;
    assign act_a = {a2, a1, a0, arun, adone, awrap};
    assign act_b = {b2, b1, b0, brun, bdone, bwrap};

    always @(negedge clk) begin
        if (reset_n) begin
            tests++;
            if (act_a !== expect_vec(0)) begin
                failed++;
                $display("FAIL model_a t=%0t got %h want %h",
                         $time, act_a, expect_vec(0));
            end
            tests++;
            if (act_b !== expect_vec(1)) begin
                failed++;
                $display("FAIL model_b t=%0t got %h want %h",
                         $time, act_b, expect_vec(1));
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        start = 0; stop = 0; clear = 0; tick = 0; load = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1;
            cyc();
        end
    endtask

    task automatic do_load(input logic [3:0] d2, d1, d0);
        ld2 = d2; ld1 = d1; ld0 = d0;
        load = 1;
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {1'b0, a2, a1, a0, arun, adone, awrap}, 16'h0);
        #1;
        reset_n = 1;
        cyc();

        start = 1; cyc();
        ticks(5);
        chk("five_ticks", {a2, a1, a0}, 12'h005);
        chk("five_run", {15'd0, arun}, 16'd1);

        reset_n = 0;
        #1;
        chk("async_rst", {4'd0, a2, a1, a0}, 16'h0);
        chk("async_run", {14'd0, arun, brun}, 16'd0);
        cyc();
        reset_n = 1;
        cyc();

        start = 1; cyc();
        ticks(12);
        chk("term_reach", {a2, a1, a0}, 12'h012);
        chk("term_run", {14'd0, arun, adone}, 16'b10);
        ticks(1);
        chk("term_done", {a2, a1, a0, arun, adone, awrap}, 15'h0092);
        ticks(1);
        start = 1; cyc();
        ticks(1);
        chk("done_hold", {a2, a1, a0, arun, adone}, 14'h0049);
        chk("b_count", {b2, b1, b0}, 12'h015);

        ticks(90);
        chk("b_at_term", {b2, b1, b0}, 12'h105);
        ticks(1);
        chk("b_wrap", {b2, b1, b0, brun, bwrap}, 14'h0003);
        cyc();
        chk("b_wrap_one", {15'd0, bwrap}, 16'd0);

        clear = 1; cyc();
        start = 1; cyc();
        ticks(41);
        chk("b_41", {b2, b1, b0}, 12'h041);
        stop = 1; tick = 1; cyc();
        chk("stop_tick", {b2, b1, b0, brun}, 13'h0082);
        clear = 1; start = 1; cyc();
        chk("clr_start", {a2, a1, a0, arun, adone, brun}, 15'h0);

`ifdef BCD_CNT_LOAD_EN
        do_load(4'hC, 4'h3, 4'hF);
        chk("ld_clamp", {b2, b1, b0}, 12'h939);
        start = 1; cyc();
        do_load(4'h0, 4'h0, 4'h0);
        chk("ld_in_run", {b2, b1, b0}, 12'h939);
        stop = 1; cyc();
        do_load(4'h9, 4'h9, 4'h8);
        start = 1; cyc();
        ticks(1);
        chk("ld_999", {b2, b1, b0}, 12'h999);
        ticks(1);
        chk("roll_nowrap", {b2, b1, b0, brun, bwrap}, 14'h0002);
        clear = 1; cyc();
        do_load(4'h0, 4'h9, 4'h9);
        start = 1; cyc();
        ticks(1);
        chk("carry_100", {b2, b1, b0}, 12'h100);
        stop = 1; cyc();
        do_load(4'h9, 4'h0, 4'h9);
        start = 1; cyc();
        ticks(1);
        chk("carry_910", {a2, a1, a0}, 12'h910);
`endif

        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
